// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART register block.
// Contents: register indices (reg_addr[4:2]), STATUS bit positions,
// the TX FSM state enum and the register-window select bit.
package mmio_uart_pkg;

    // reg_addr bit that selects the register window
    localparam int unsigned WIN_BIT = 14;

    // Register indices decoded from reg_addr[4:2]
    localparam logic [2:0] REG_TXDATA  = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_BAUDDIV = 3'd2;
    localparam logic [2:0] REG_CYCLE   = 3'd3;
    localparam logic [2:0] REG_IRQEN   = 3'd4;

    // STATUS register layout
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_sync_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered count/full/empty.
// Ports:
//   clk, reset   - clock, async active-low reset (flushes pointers/count)
//   push, wdata  - write request; ignored when full (pre-edge)
//   pop          - read request; ignored when empty
//   head_c       - combinational view of the oldest entry
//   count        - number of stored entries
//   full, empty  - registered flags
module mmio_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head_c,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Acceptance uses the pre-edge flags, so a pop never frees a slot for a same-cycle push
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/mmio_uart_regs.sv
// Memory-mapped UART peripheral: TX byte FIFO, 8N1 transmitter, programmable
// baud divider and free-running 32-bit cycle counter.
// Optional feature macro: MMIO_UART_IRQ_EN (adds IRQEN register and irq logic).
// Ports:
//   clk            - system clock, rising edge
//   reset          - asynchronous active-low reset
//   reg_addr       - byte address; bit 14 = window hit, bits[4:2] = register
//   reg_write      - store strobe
//   write_reg_data - store data
//   reg_data       - combinational load data (0 on window miss)
//   uart_tx        - registered serial output, idle high
//   irq            - registered interrupt (0 without MMIO_UART_IRQ_EN)
module mmio_uart_regs
    import mmio_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned DIV_W            = 16,
    parameter int unsigned DEFAULT_BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_addr,
    input  logic        reg_write,
    input  logic [31:0] write_reg_data,
    output logic [31:0] reg_data,
    output logic        uart_tx,
    output logic        irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    logic [2:0]       idx;
    logic             wr_en;
    logic             unused_addr;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [DIV_W-1:0] bcnt_q, bcnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      cyc_q, cyc_d;

    logic [DIV_W-1:0] eff_div;
    logic             bit_end;
    logic             start_frame;
    logic             busy;
    logic [31:0]      status;

    assign hit         = reg_addr[WIN_BIT];
    assign idx         = reg_addr[4:2];
    assign wr_en       = reg_write && hit;
    assign unused_addr = ^{reg_addr[31:WIN_BIT+1], reg_addr[WIN_BIT-1:5], reg_addr[1:0]};

    assign fifo_push   = wr_en && (idx == REG_TXDATA);

    mmio_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (write_reg_data[7:0]),
        .head_c (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A programmed divisor of 0 behaves as 1 clock per bit
    assign eff_div     = (baud_q == '0) ? DIV_W'(1) : baud_q;
    assign bit_end     = (bcnt_q == '0);
    assign busy        = (state_q != ST_IDLE);
    // New frame from IDLE, or back-to-back straight out of the last STOP clock
    assign start_frame = !fifo_empty &&
                         ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

    // TX FSM next state; uart_tx is derived from the current state, one clock behind
    always_comb begin
        state_d   = state_q;
        div_lat_d = div_lat_q;
        bcnt_d    = bcnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        tx_d      = 1'b1;

        if (start_frame) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            div_lat_d = eff_div;
            bcnt_d    = eff_div - DIV_W'(1);
            bit_d     = '0;
            state_d   = ST_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        bcnt_d  = div_lat_q - DIV_W'(1);
                    end else begin
                        bcnt_d = bcnt_q - DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bcnt_d  = div_lat_q - DIV_W'(1);
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        bcnt_d = bcnt_q - DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_d = ST_IDLE;
                    end else begin
                        bcnt_d = bcnt_q - DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Register writes, overflow flag and cycle counter
    always_comb begin
        baud_d = baud_q;
        ovf_d  = ovf_q;
        cyc_d  = cyc_q + 32'd1;
        if (wr_en && (idx == REG_BAUDDIV)) begin
            baud_d = write_reg_data[DIV_W-1:0];
        end
        if (wr_en && (idx == REG_CYCLE)) begin
            cyc_d = write_reg_data;
        end
        if (fifo_push && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_en && (idx == REG_STATUS) && write_reg_data[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        status                                  = '0;
        status[STAT_BUSY]                       = busy;
        status[STAT_FULL]                       = fifo_full;
        status[STAT_EMPTY]                      = fifo_empty;
        status[STAT_OVF]                        = ovf_q;
        status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(fifo_count);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= DIV_W'(DEFAULT_BAUD_DIV);
            div_lat_q <= DIV_W'(1);
            bcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            div_lat_q <= div_lat_d;
            bcnt_q    <= bcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            cyc_q     <= cyc_d;
        end
    end

    assign uart_tx = tx_q;

`ifdef MMIO_UART_IRQ_EN
    logic [1:0] irqen_q, irqen_d;
    logic       irq_q, irq_d;

    // IRQEN[0]: drained and idle; IRQEN[1]: overflow
    always_comb begin
        irqen_d = irqen_q;
        if (wr_en && (idx == REG_IRQEN)) begin
            irqen_d = write_reg_data[1:0];
        end
        irq_d = (irqen_q[0] && fifo_empty && !busy) || (irqen_q[1] && ovf_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // Load data mux; a read during a CYCLE write sees the pre-edge count
    always_comb begin
        reg_data = '0;
        if (hit) begin
            case (idx)
                REG_STATUS:  reg_data = status;
                REG_BAUDDIV: reg_data = 32'(baud_q);
                REG_CYCLE:   reg_data = cyc_q;
`ifdef MMIO_UART_IRQ_EN
                REG_IRQEN:   reg_data = 32'(irqen_q);
`endif
                default:     reg_data = '0;
            endcase
        end
    end

`ifndef MMIO_UART_IRQ_EN
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_uart_regs.sv
// Directed self-checking bench for mmio_uart_regs: a register-access vector
// table followed by hand-timed sequences for frame timing, FIFO overflow,
// back-to-back frames, the cycle counter, reset abort and (optionally) irq.
module tb_mmio_uart_regs;

    localparam logic [31:0] A_TXDATA  = 32'h0000_4000;
    localparam logic [31:0] A_STATUS  = 32'h0000_4004;
    localparam logic [31:0] A_BAUDDIV = 32'h0000_4008;
    localparam logic [31:0] A_CYCLE   = 32'h0000_400C;
    localparam logic [31:0] A_IRQEN   = 32'h0000_4010;

    logic        clk;
    logic        reset;
    logic [31:0] reg_addr;
    logic        reg_write;
    logic [31:0] write_reg_data;
    logic [31:0] reg_data;
    logic        uart_tx;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    mmio_uart_regs #(
        .FIFO_DEPTH       (8),
        .DIV_W            (16),
        .DEFAULT_BAUD_DIV (434)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .reg_addr       (reg_addr),
        .reg_write      (reg_write),
        .write_reg_data (write_reg_data),
        .reg_data       (reg_data),
        .uart_tx        (uart_tx),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the write edge
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        reg_addr       = addr;
        write_reg_data = data;
        reg_write      = 1'b1;
        @(posedge clk);
        #1;
        reg_write      = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        reg_addr  = addr;
        reg_write = 1'b0;
        #1;
        data = reg_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial frame: bit0 = start, bits1..8 = data LSB first, bit9 = stop
    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        logic done;
        done      = 1'b0;
        reg_addr  = A_STATUS;
        reg_write = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            tick();
            if (reg_data[0] == 1'b0 && reg_data[2] == 1'b1) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  fr;
        logic [9:0]  fr2;

        reset          = 1'b0;
        reg_addr       = '0;
        reg_write      = 1'b0;
        write_reg_data = '0;

        vecs[0]  = '{A_STATUS,        1'b0, 32'h0,         32'h0000_0004};
        vecs[1]  = '{A_BAUDDIV,       1'b0, 32'h0,         32'd434};
        vecs[2]  = '{A_TXDATA,        1'b0, 32'h0,         32'h0};
        vecs[3]  = '{A_IRQEN,         1'b0, 32'h0,         32'h0};
        vecs[4]  = '{32'h0000_4014,   1'b0, 32'h0,         32'h0};
        vecs[5]  = '{32'h0000_401C,   1'b0, 32'h0,         32'h0};
        vecs[6]  = '{32'h0000_0004,   1'b0, 32'h0,         32'h0};
        vecs[7]  = '{A_BAUDDIV,       1'b1, 32'h0001_2345, 32'h0};
        vecs[8]  = '{A_BAUDDIV,       1'b0, 32'h0,         32'h0000_2345};
        vecs[9]  = '{32'h0000_0008,   1'b1, 32'h7,         32'h0};
        vecs[10] = '{32'h8000_4008,   1'b0, 32'h0,         32'h0000_2345};
        vecs[11] = '{32'h0000_0000,   1'b1, 32'h55,        32'h0};
        vecs[12] = '{A_STATUS,        1'b0, 32'h0,         32'h0000_0004};
        vecs[13] = '{32'h0000_4018,   1'b1, 32'hFFFF,      32'h0};
        vecs[14] = '{32'h0000_4018,   1'b0, 32'h0,         32'h0};
        vecs[15] = '{32'h0000_4024,   1'b0, 32'h0,         32'h0000_0004};

        // Reset state
        #12;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        #11 reset = 1'b1;
        tick();
        do_read(A_CYCLE, rd);
        check("cycle_first", rd, 32'd1);
        tick();
        check("cycle_second", reg_data, 32'd2);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) begin
                do_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read(vecs[i].addr, rd);
                check($sformatf("vec[%0d] addr=%08h", i, vecs[i].addr), rd, vecs[i].exp);
                tick();
            end
        end

        // Cycle counter: same-cycle read sees old value, load, wrap
        do_write(A_CYCLE, 32'h0000_1000);
        reg_addr       = A_CYCLE;
        write_reg_data = 32'hFFFF_FFFE;
        reg_write      = 1'b1;
        #1;
        check("cycle_rd_during_wr", reg_data, 32'h0000_1000);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        check("cycle_loaded", reg_data, 32'hFFFF_FFFE);
        tick();
        check("cycle_ffff", reg_data, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap0", reg_data, 32'h0000_0000);
        tick();
        check("cycle_wrap1", reg_data, 32'h0000_0001);

        // Single 0xA5 frame at 4 clocks per bit
        tick();
        do_write(A_BAUDDIV, 32'd4);
        do_write(A_TXDATA, 32'h0000_00A5);
        reg_addr = A_STATUS;
        fr = frame(8'hA5);
        for (int n = 1; n <= 41; n++) begin
            tick();
            if (n == 1) check("a5_still_idle_line", 32'(uart_tx), 32'd1);
            else check($sformatf("a5_line n=%0d", n), 32'(uart_tx), 32'(fr[(n-2)/4]));
            if (n == 40) check("a5_busy_before_end", 32'(reg_data[0]), 32'd1);
            if (n == 41) check("a5_status_after", reg_data, 32'h0000_0004);
        end

        // Fill, overflow, clear, and overflow coinciding with a pop
        do_write(A_BAUDDIV, 32'd2);
        for (int i = 1; i <= 9; i++) do_write(A_TXDATA, 32'(i));
        do_read(A_STATUS, rd);
        check("ovf_full_status", rd, 32'h0000_0803);
        do_write(A_TXDATA, 32'h0000_00AA);
        do_read(A_STATUS, rd);
        check("ovf_set_status", rd, 32'h0000_080B);
        check("ovf_irq_disabled", 32'(irq), 32'd0);
        do_write(A_STATUS, 32'h0000_0008);
        do_read(A_STATUS, rd);
        check("ovf_cleared", rd, 32'h0000_0803);
        for (int n = 0; n < 10; n++) tick();
        do_write(A_TXDATA, 32'h0000_00EE);
        do_read(A_STATUS, rd);
        check("ovf_full_with_pop", rd, 32'h0000_0709);
        tick();
        do_write(A_STATUS, 32'h0000_0008);
        wait_idle("ovf_drain", 400);
        check("ovf_drained_status", reg_data, 32'h0000_0004);

        // Two queued frames at 3 clocks per bit: 30-clock pitch, no gap
        do_write(A_BAUDDIV, 32'd3);
        do_write(A_TXDATA, 32'h0000_00FF);
        do_write(A_TXDATA, 32'h0000_0001);
        fr  = frame(8'hFF);
        fr2 = frame(8'h01);
        for (int n = 2; n <= 41; n++) begin
            tick();
            if (n < 32) check($sformatf("pitch_f1 n=%0d", n), 32'(uart_tx), 32'(fr[(n-2)/3]));
            else check($sformatf("pitch_f2 n=%0d", n), 32'(uart_tx), 32'(fr2[(n-32)/3]));
        end
        wait_idle("pitch_drain", 200);

        // Reset during a data bit aborts the frame and flushes the FIFO
        do_write(A_BAUDDIV, 32'd4);
        do_write(A_TXDATA, 32'h0000_0000);
        do_write(A_TXDATA, 32'h0000_0011);
        do_write(A_TXDATA, 32'h0000_0022);
        for (int n = 0; n < 5; n++) tick();
        check("abort_pre_low", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_tx_high", 32'(uart_tx), 32'd1);
        check("abort_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        do_read(A_STATUS, rd);
        check("abort_status", rd, 32'h0000_0004);
        do_read(A_BAUDDIV, rd);
        check("abort_bauddiv", rd, 32'd434);
        check("abort_tx_after", 32'(uart_tx), 32'd1);
        tick();

`ifdef MMIO_UART_IRQ_EN
        // Empty-and-idle interrupt drops while a frame is in flight
        do_write(A_BAUDDIV, 32'd2);
        do_write(A_IRQEN, 32'h0000_0001);
        check("irq_after_en_edge", 32'(irq), 32'd0);
        tick();
        check("irq_idle_empty", 32'(irq), 32'd1);
        do_read(A_IRQEN, rd);
        check("irqen_readback", rd, 32'h0000_0001);
        do_write(A_TXDATA, 32'h0000_005A);
        check("irq_push_edge", 32'(irq), 32'd1);
        tick();
        check("irq_dropped", 32'(irq), 32'd0);
        for (int n = 0; n < 10; n++) tick();
        check("irq_mid_frame", 32'(irq), 32'd0);
        wait_idle("irq_drain", 100);
        tick();
        check("irq_restored", 32'(irq), 32'd1);
`else
        // Without the option, IRQEN is absent and irq stays low
        do_write(A_IRQEN, 32'h0000_0003);
        do_read(A_IRQEN, rd);
        check("irqen_absent", rd, 32'h0);
        tick();
        tick();
        check("irq_tied_low", 32'(irq), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
